// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing for the 1 MHz board clock at 9600 baud,
// frame width and the receiver FSM state encoding.
package uart_pkg;

    // 1 MHz / 9600 baud, rounded to whole clock cycles
    localparam int CLKS_PER_BIT = 104;
    // Delay from start-edge detection to the middle of the start bit
    localparam int CLKS_HALF    = 52;
    // Payload width of one frame, shared with the transmitter
    localparam int DATA_BITS    = 8;

    // Counter widths: 7 bits covers CLKS_PER_BIT-1, 4 bits covers DATA_BITS-1
    localparam int CNT_W = 7;
    localparam int BIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so an idle-high line does not look like a start bit after reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff_reg;

    // Shift the raw input through two flops; the second stage is the clean output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_reg <= {2{RESET_VAL}};
        end else begin
            ff_reg <= {ff_reg[0], d};
        end
    end

    assign q = ff_reg[1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises rxd, finds the start edge, samples each bit
// at its centre and reports a byte with a one-cycle valid or framing-error pulse.
module uart_rx_byte
    import uart_pkg::*;
(
    input  logic                 clk1mhz,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    // Counter terminal values: the counter is cleared on the sample edge, so
    // the next sample falls when it reaches (interval - 1)
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rxd_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk1mhz),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    // Receiver FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk1mhz or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (!rxd_s) begin
                        cycle_cnt <= '0;
                        state     <= ST_START;
                        busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cycle_cnt == HALF_LAST) begin
                        cycle_cnt <= '0;
                        if (rxd_s) begin
                            // Line already back high at mid-bit: glitch, not a start
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= '0;
                        shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cycle_cnt == BIT_LAST) begin
                        cycle_cnt <= '0;
                        if (rxd_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            // Keep the old byte; wait for the line to recover
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: directed frames, a timing-level reference model
// checked every cycle, and literal expectations for each scenario.
module tb_uart_rx_byte;

    logic       clk1mhz;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_rx_byte dut (
        .clk1mhz   (clk1mhz),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk1mhz = 1'b0;
    always #5 clk1mhz = ~clk1mhz;

    always @(posedge clk1mhz) cyc++;

    // ---------------- reference model ----------------
    // Works on absolute time: the line seen by the receiver is rxd two edges
    // late; a frame found at edge t0 is sampled at t0 + 52 + 104*k.
    bit         line_q[$];
    bit         s;
    int         m_mode = 0;   // 0 idle, 1 in frame, 2 waiting for high line
    int         m_n = 0;
    int         m_t0 = 0;
    int         rel;
    int         k;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_busy = 1'b0;

    always @(posedge clk1mhz or posedge reset) begin
        if (reset) begin
            line_q    = {1'b1, 1'b1};
            m_mode    = 0;
            m_n       = 0;
            exp_data  = 8'h00;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            s = line_q.pop_front();
            line_q.push_back(rxd);
            m_n++;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            if (m_mode == 0) begin
                if (!s) begin
                    m_t0   = m_n;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                rel = m_n - m_t0 - 52;
                if (rel >= 0 && rel % 104 == 0) begin
                    k = rel / 104;
                    if (k == 0) begin
                        if (s) m_mode = 0;
                    end else if (k <= 8) begin
                        m_byte[k-1] = s;
                    end else begin
                        if (s) begin
                            exp_data  = m_byte;
                            exp_valid = 1'b1;
                            m_mode    = 0;
                        end else begin
                            exp_ferr = 1'b1;
                            m_mode   = 2;
                        end
                    end
                end
            end else begin
                if (s) m_mode = 0;
            end
            exp_busy = (m_mode != 0);
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk1mhz) begin
        n_vec++;
        if ({rx_data, rx_valid, frame_err, busy} !== {exp_data, exp_valid, exp_ferr, exp_busy}) begin
            n_err++;
            $display("FAIL model cyc=%0d: got data=%h valid=%b ferr=%b busy=%b, expected data=%h valid=%b ferr=%b busy=%b",
                     cyc, rx_data, rx_valid, frame_err, busy, exp_data, exp_valid, exp_ferr, exp_busy);
        end
    end

    // ---------------- event monitor ----------------
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         busy_cnt = 0;
    int         first_valid_cyc = 0;
    int         last_valid_cyc = 0;
    logic [7:0] first_valid_data = 8'h00;
    int         start_cyc = 0;

    always @(negedge clk1mhz) begin
        if (rx_valid) begin
            if (valid_cnt == 0) begin
                first_valid_cyc  = cyc;
                first_valid_data = rx_data;
            end
            last_valid_cyc = cyc;
            valid_cnt++;
        end
        if (frame_err) ferr_cnt++;
        if (busy) busy_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        busy_cnt  = 0;
    endtask

    task automatic level(input logic v, input int cycles);
        rxd = v;
        repeat (cycles) @(posedge clk1mhz);
        #1;
    endtask

    // Drive one 8N1 frame; first edge seeing the start bit is recorded
    task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_level);
        start_cyc = cyc + 1;
        level(1'b0, cpb);
        for (int i = 0; i < 8; i++) level(b[i], cpb);
        level(stop_level, cpb);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rxd   = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk1mhz);
        #1;
        chk("reset_outputs", {rx_data, rx_valid, frame_err, busy}, 11'h000);
        reset = 1'b0;
        level(1'b1, 20);

        // 0xA5: valid 990 edges after the line first goes low
        clear_counts();
        send_byte(8'hA5, 104, 1'b1);
        level(1'b1, 20);
        chk("a5_valid_count", valid_cnt, 1);
        chk("a5_latency", last_valid_cyc - start_cyc, 990);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_no_ferr", ferr_cnt, 0);

        // Back-to-back 0x00 then 0xFF
        clear_counts();
        send_byte(8'h00, 104, 1'b1);
        send_byte(8'hFF, 104, 1'b1);
        level(1'b1, 20);
        chk("b2b_valid_count", valid_cnt, 2);
        chk("b2b_first_data", first_valid_data, 8'h00);
        chk("b2b_spacing", last_valid_cyc - first_valid_cyc, 1040);
        chk("b2b_last_data", rx_data, 8'hFF);

        // 20-cycle glitch: rejected at mid-start, busy for 52 cycles
        clear_counts();
        level(1'b0, 20);
        level(1'b1, 200);
        chk("glitch_valid", valid_cnt, 0);
        chk("glitch_ferr", ferr_cnt, 0);
        chk("glitch_busy_cycles", busy_cnt, 52);

        // 0x3C with low stop bit, line held low 500 more cycles
        clear_counts();
        send_byte(8'h3C, 104, 1'b0);
        level(1'b0, 500);
        level(1'b1, 100);
        chk("ferr_count", ferr_cnt, 1);
        chk("ferr_no_valid", valid_cnt, 0);
        chk("ferr_data_kept", rx_data, 8'hFF);
        chk("ferr_busy_cycles", busy_cnt, 1540);

        // Reset in the middle of 0x5A, then a clean 0x81
        clear_counts();
        level(1'b0, 104);           // start
        level(1'b0, 104);           // bit0 of 0x5A
        level(1'b1, 104);           // bit1
        level(1'b0, 50);            // part of bit2
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(posedge clk1mhz);
        #1;
        chk("midreset_outputs", {rx_data, rx_valid, frame_err, busy}, 11'h000);
        reset = 1'b0;
        level(1'b1, 50);
        chk("midreset_no_pulse", valid_cnt + ferr_cnt, 0);
        send_byte(8'h81, 104, 1'b1);
        level(1'b1, 20);
        chk("x81_valid_count", valid_cnt, 1);
        chk("x81_data", rx_data, 8'h81);

        // Bit-rate tolerance
        clear_counts();
        send_byte(8'h55, 100, 1'b1);
        level(1'b1, 60);
        chk("slow_fast_100_valid", valid_cnt, 1);
        chk("rate100_data", rx_data, 8'h55);
        clear_counts();
        send_byte(8'h55, 108, 1'b1);
        level(1'b1, 60);
        chk("rate108_valid", valid_cnt, 1);
        chk("rate108_data", rx_data, 8'h55);
        chk("rate_no_ferr", ferr_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
8N1 UART receiver for the 1 MHz clock domain of the clock board; the serial-input counterpart of the board's UART transmitter. Samples the asynchronous `rxd` pin, recovers one byte per frame at 9600 baud and presents it with a single-cycle valid strobe to the time-setting/command logic. Flags framing errors and rejects glitch start bits.

Parameters:
CLKS_PER_BIT, 104, clk1mhz cycles per bit (1 MHz / 9600 ≈ 104)
CLKS_HALF, 52, cycles from start-edge detection to the start-bit mid-sample

Ports:
clk1mhz  in  1  1 MHz system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rxd  in  1  raw serial input, idle high, asynchronous to clk1mhz
rx_data  out  8  last correctly received byte, LSB first on the line
rx_valid  out  1  one-cycle pulse when rx_data is updated
frame_err  out  1  one-cycle pulse when the stop bit samples low
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock, `clk1mhz`. Reset is `reset`, asynchronous and active-high.
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, FSM=IDLE, bit counter=0, cycle counter=0, synchroniser flops=1.
- Synchroniser: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: the edge where rxd_s==0 is detection edge T0. On that edge, clear the cycle counter and go to START.
- Sample points: edges T0+CLKS_HALF+k*CLKS_PER_BIT.
  - k=0: start bit.
  - k=1..8: data bits 0..7.
  - k=9: stop bit.
  - With default parameters the stop sample is at T0+988.
- START: at the k=0 sample, if rxd_s==1 the start is false. Return to IDLE with no outputs pulsed. Otherwise go to DATA.
- DATA: shift rxd_s into the shift register at each sample, LSB first. After bit 7, go to STOP.
- STOP, at the k=9 sample:
  - rxd_s==1: rx_data is loaded from the shift register and rx_valid=1 on that same edge, so both are visible in the following cycle. Go to IDLE.
  - rxd_s==0: frame_err=1 for one cycle and rx_data is unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s==1, then go to IDLE. A held-low line or break therefore produces exactly one frame_err, not repeated frames.
- Pulses: rx_valid and frame_err are never high in the same cycle. Each is high for exactly one cycle. rx_data holds its value until the next valid frame.
- Back-to-back frames: after the stop sample, a start edge is accepted from the next IDLE cycle onward. There is no dead time beyond that one cycle.
- No overrun buffering: the consumer must take rx_data within one frame time (~1040 cycles).
- Reset mid-frame: returns to IDLE immediately. A partially shifted byte is discarded and no pulse is emitted.
- Counters:
  - Cycle counter: 7 bits, saturates never, cleared at every sample point.
  - Bit counter: 4 bits.

Decomposition:
- Shared package `uart_pkg`: CLKS_PER_BIT, CLKS_HALF and the FSM state encodings. Also DATA_BITS=8, reused by the transmitter.
- One sub-module, `uart_sync2`: a 2-flop synchroniser with the reset value as a parameter (1 here).

Test Plan:
- Send 0xA5 at 104 cycles/bit, 8N1 → rx_valid for exactly one cycle at T0+989 (as seen after the edge), rx_data=8'hA5, frame_err=0 throughout.
- Send 0x00 then 0xFF back-to-back with no idle gap → two rx_valid pulses about 1040 cycles apart, rx_data=8'h00 then 8'hFF.
- Low glitch of 20 cycles on idle rxd → no rx_valid, no frame_err; busy high for about 52 cycles, then returns to IDLE.
- Frame 0x3C with the stop bit forced low, line then held low for 500 cycles, then high → exactly one frame_err pulse, rx_data keeps its previous value, busy stays high until rxd_s is high again.
- Assert reset for 3 cycles mid-frame while receiving 0x5A, then send a clean 0x81 → no pulse for 0x5A, all outputs at reset values during reset, then rx_data=8'h81 with one rx_valid.
- Bit-rate tolerance: send 0x55 at 100 and at 108 cycles/bit → rx_data=8'h55 with rx_valid in both cases.
